quad_sqrt: RTL and testbench

Iterative integer square-root stage that sits directly downstream of the sum-of-squares block `quad`. It consumes the 18-bit energy word (a² + b²) and returns the floor magnitude √(a² + b²) plus remainder. It uses a restoring digit-by-digit algorithm that produces one root bit per clock. Input and output use valid/ready handshakes so the stage can be placed behind a free-running `quad` output register or a FIFO.

---
 rtl/quad_pkg.sv | 7 +
 rtl/sqrt_step.sv | 27 ++
 rtl/quad_sqrt.sv | 85 ++++++++
 tb/tb_quad_sqrt.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// Shared definitions for the quad sum-of-squares block and its square-root stage.
package quad_pkg;
    localparam int QUAD_SUM_W  = 18;
    localparam int QUAD_ROOT_W = QUAD_SUM_W / 2;

    typedef enum logic [1:0] {IDLE, CALC, DONE} sqrt_state_t;
endpackage

// File: rtl/sqrt_step.sv
// One restoring digit-by-digit square-root iteration: consumes two radicand bits,
// produces one root bit and the updated partial remainder.
module sqrt_step #(
    parameter int OUT_W = 9
) (
    input  logic [OUT_W+1:0] i_rem,
    input  logic [OUT_W-1:0] i_root,
    input  logic [1:0]       i_bits,
    output logic [OUT_W+1:0] o_rem,
    output logic [OUT_W-1:0] o_root
);
    logic [OUT_W+1:0] w_r;
    logic [OUT_W+1:0] w_t;

    // The remainder never exceeds 2*root, so the shifted value fits OUT_W+2 bits.
    always_comb begin
        w_r = (i_rem << 2) | {{OUT_W{1'b0}}, i_bits};
        w_t = {i_root, 2'b01};
        if (w_r >= w_t) begin
            o_rem  = w_r - w_t;
            o_root = {i_root[OUT_W-2:0], 1'b1};
        end else begin
            o_rem  = w_r;
            o_root = {i_root[OUT_W-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/quad_sqrt.sv
// Iterative integer square root of the quad energy word: one root bit per clock,
// valid/ready on both sides, floor root plus remainder out.
module quad_sqrt
    import quad_pkg::*;
#(
    parameter int IN_W  = QUAD_SUM_W,
    parameter int OUT_W = IN_W / 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_root,
    output logic [OUT_W:0]   out_rem
);
    localparam int CW = $clog2(OUT_W);

    sqrt_state_t      r_state;
    logic [IN_W-1:0]  r_rad;
    logic [OUT_W+1:0] r_rem;
    logic [OUT_W-1:0] r_root;
    logic [CW-1:0]    r_cnt;
    logic             r_out_valid;

    logic [OUT_W+1:0] w_rem;
    logic [OUT_W-1:0] w_root;

    sqrt_step #(.OUT_W(OUT_W)) u_step (
        .i_rem  (r_rem),
        .i_root (r_root),
        .i_bits (r_rad[IN_W-1:IN_W-2]),
        .o_rem  (w_rem),
        .o_root (w_root)
    );

    assign in_ready  = (r_state == IDLE) && !rst;
    assign out_valid = r_out_valid;
    assign out_root  = r_root;
    assign out_rem   = r_rem[OUT_W:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rad       <= '0;
            r_rem       <= '0;
            r_root      <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_rad   <= in_data;
                        r_rem   <= '0;
                        r_root  <= '0;
                        r_cnt   <= CW'(OUT_W - 1);
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    r_rem  <= w_rem;
                    r_root <= w_root;
                    r_rad  <= {r_rad[IN_W-3:0], 2'b00};
                    // Result registers and out_valid land on the same edge as the last step.
                    if (r_cnt == '0) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_quad_sqrt.sv
// Directed and swept checks of quad_sqrt against an independent integer-sqrt model.
module tb_quad_sqrt;
    localparam int IW = 18;
    localparam int OW = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_root;
    logic [OW:0]   out_rem;

    int total = 0;
    int bad   = 0;

    quad_sqrt dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_root  (out_root),
        .out_rem   (out_rem)
    );

    always #5 clk = ~clk;

    function automatic int isqrt(input int x);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic do_one(input int x, input int stall_max);
        int n;
        int k;
        int e;
        logic [OW-1:0] hr;
        logic [OW:0]   hm;
        in_data  = IW'(x);
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 40) begin @(posedge clk); #1; n++; end
        chk("accept_wait", {31'd0, in_ready}, 1);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
        chk("latency", n, OW);
        hr = out_root;
        hm = out_rem;
        e  = isqrt(x);
        chk("root", {23'd0, hr}, e);
        chk("rem", {22'd0, hm}, x - e * e);
        chk("rem_le_2root", {31'd0, (32'(hm) <= 2 * 32'(hr))}, 1);
        k = (stall_max > 0) ? int'($urandom_range(stall_max, 0)) : 0;
        repeat (k) begin
            @(posedge clk); #1;
            chk("stall_hold", {11'd0, out_valid, in_ready, out_root, out_rem},
                {11'd0, 1'b1, 1'b0, hr, hm});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release", {31'd0, out_valid}, 0);
    endtask

    int vals[5];
    int q[$];
    int ai, ri, last_acc, cyc, e, lowcnt;
    logic acc, hs;
    logic [OW-1:0] ro;
    logic [OW:0]   re;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready", {31'd0, in_ready}, 0);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_root", {23'd0, out_root}, 0);
        chk("rst_rem", {22'd0, out_rem}, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 1);
        @(posedge clk); #1;

        // basic values and extremes
        do_one(0, 0);
        do_one(100, 0);
        do_one(99, 0);
        do_one(262143, 0);
        do_one(65536, 0);

        // backpressure in DONE with in_valid/in_data churning
        in_data  = 18'd200;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (OW) @(posedge clk);
        #1;
        chk("bp_valid", {31'd0, out_valid}, 1);
        chk("bp_root", {23'd0, out_root}, 14);
        chk("bp_rem", {22'd0, out_rem}, 4);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            in_data  = IW'($urandom);
            @(posedge clk); #1;
            chk("bp_in_ready", {31'd0, in_ready}, 0);
            chk("bp_hold", {12'd0, out_valid, out_root, out_rem}, {12'd0, 1'b1, 9'd14, 10'd4});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release", {31'd0, out_valid}, 0);
        chk("bp_no_accept", {31'd0, in_ready}, 1);

        // reset in the middle of CALC
        in_data  = 18'd50000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", {31'd0, in_ready}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_out", {12'd0, out_valid, out_root, out_rem}, 0);
        lowcnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) lowcnt++;
            @(posedge clk); #1;
        end
        chk("midrst_no_emit", lowcnt, 0);
        do_one(144, 0);

        // back-to-back streaming
        vals = '{1000, 4, 262143, 12345, 17};
        ai = 0; ri = 0; last_acc = -1; cyc = 0;
        in_data   = IW'(vals[0]);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        while (ri < 5 && cyc < 100) begin
            acc = in_ready && in_valid;
            hs  = out_valid;
            ro  = out_root;
            re  = out_rem;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                if (last_acc >= 0) chk("b2b_interval", cyc - last_acc, OW + 2);
                last_acc = cyc;
                q.push_back(vals[ai]);
                ai++;
                if (ai < 5) in_data = IW'(vals[ai]);
                else in_valid = 1'b0;
            end
            if (hs && q.size() > 0) begin
                e = q.pop_front();
                chk("b2b_root", {23'd0, ro}, isqrt(e));
                chk("b2b_rem", {22'd0, re}, e - isqrt(e) * isqrt(e));
                ri++;
            end
        end
        chk("b2b_count", ri, 5);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;

        // boundary and random sweep with output stalls
        for (int k = 1; k < 512; k++) begin
            do_one(k * k - 1, 2);
            do_one(k * k, 2);
            do_one(k * k + 2 * k, 2);
        end
        for (int i = 0; i < 2000; i++) do_one(int'($urandom_range(262143, 0)), 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
